// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, op/func enums and immediate-range helper.
// INST_ENCODER_LI_EN (in the encoder) decides whether OP_LI is encodable.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [3:0] {
    OP_RALU = 4'd0, OP_IALU = 4'd1, OP_LUI = 4'd2, OP_AUIPC = 4'd3, OP_JAL = 4'd4,
    OP_JALR = 4'd5, OP_BRANCH = 4'd6, OP_LOAD = 4'd7, OP_STORE = 4'd8, OP_LI = 4'd9
  } op_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4,
    ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9
  } alu_e;

  typedef enum logic [2:0] {
    BR_BEQ = 3'd0, BR_BNE = 3'd1, BR_BLT = 3'd2, BR_BGE = 3'd3, BR_BLTU = 3'd4, BR_BGEU = 3'd5
  } br_e;

  function automatic logic [2:0] alu_funct3(input logic [3:0] f);
    case (f)
      ALU_SLL:          return 3'b001;
      ALU_SLT:          return 3'b010;
      ALU_SLTU:         return 3'b011;
      ALU_XOR:          return 3'b100;
      ALU_SRL, ALU_SRA: return 3'b101;
      ALU_OR:           return 3'b110;
      ALU_AND:          return 3'b111;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] br_funct3(input logic [2:0] f);
    case (f)
      BR_BNE:  return 3'b001;
      BR_BLT:  return 3'b100;
      BR_BGE:  return 3'b101;
      BR_BLTU: return 3'b110;
      BR_BGEU: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // True when v is representable as a two's-complement number of 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packing and legality checks for one request.
// With INST_ENCODER_LI_EN, LI may also yield a second (ADDI) word.
module inst_pack
  import riscv_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [3:0]  alu_func_i,
  input  logic [2:0]  br_func_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
`ifdef INST_ENCODER_LI_EN
  output logic        two_word_o,
  output logic [31:0] inst2_o,
`endif
  output logic [31:0] inst_o,
  output logic        err_o
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       alu_ok;
  logic       is_shift;
`ifdef INST_ENCODER_LI_EN
  logic [19:0] hi20;
`endif

  always_comb begin
    inst_o   = NOP;
    err_o    = 1'b0;
    f3       = alu_funct3(alu_func_i);
    f7       = (alu_func_i == ALU_SUB || alu_func_i == ALU_SRA) ? 7'h20 : 7'h00;
    alu_ok   = (alu_func_i <= ALU_SRA);
    is_shift = (alu_func_i == ALU_SLL) || (alu_func_i == ALU_SRL) || (alu_func_i == ALU_SRA);
`ifdef INST_ENCODER_LI_EN
    two_word_o = 1'b0;
    inst2_o    = NOP;
    // Rounded upper part so that the sign-extended low 12 bits add back exactly.
    hi20       = imm_i[31:12] + {19'd0, imm_i[11]};
`endif
    case (op_i)
      OP_RALU: begin
        if (!alu_ok) err_o = 1'b1;
        else inst_o = {f7, rs2_i, rs1_i, f3, rd_i, OPC_OP};
      end
      OP_IALU: begin
        if (!alu_ok || alu_func_i == ALU_SUB) err_o = 1'b1;
        else if (is_shift) begin
          if (imm_i[31:5] != '0) err_o = 1'b1;
          else inst_o = {f7, imm_i[4:0], rs1_i, f3, rd_i, OPC_OPIMM};
        end else if (!fits_signed(imm_i, 12)) err_o = 1'b1;
        else inst_o = {imm_i[11:0], rs1_i, f3, rd_i, OPC_OPIMM};
      end
      OP_LUI, OP_AUIPC: begin
        if (imm_i[11:0] != '0) err_o = 1'b1;
        else inst_o = {imm_i[31:12], rd_i, (op_i == OP_LUI) ? OPC_LUI : OPC_AUIPC};
      end
      OP_JAL: begin
        if (!fits_signed(imm_i, 21) || imm_i[0]) err_o = 1'b1;
        else inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
      end
      OP_JALR: begin
        if (!fits_signed(imm_i, 12)) err_o = 1'b1;
        else inst_o = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
      end
      OP_BRANCH: begin
        if (br_func_i > BR_BGEU || !fits_signed(imm_i, 13) || imm_i[0]) err_o = 1'b1;
        else inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, br_funct3(br_func_i),
                       imm_i[4:1], imm_i[11], OPC_BRANCH};
      end
      OP_LOAD: begin
        if (!fits_signed(imm_i, 12)) err_o = 1'b1;
        else inst_o = {imm_i[11:0], rs1_i, 3'b010, rd_i, OPC_LOAD};
      end
      OP_STORE: begin
        if (!fits_signed(imm_i, 12)) err_o = 1'b1;
        else inst_o = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], OPC_STORE};
      end
`ifdef INST_ENCODER_LI_EN
      OP_LI: begin
        if (fits_signed(imm_i, 12)) begin
          inst_o = {imm_i[11:0], 5'd0, 3'b000, rd_i, OPC_OPIMM};
        end else begin
          inst_o     = {hi20, rd_i, OPC_LUI};
          two_word_o = (imm_i[11:0] != '0);
          inst2_o    = {imm_i[11:0], rd_i, 3'b000, rd_i, OPC_OPIMM};
        end
      end
`endif
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Registered RV32I instruction encoder with valid/ready on both sides.
// Define INST_ENCODER_LI_EN to enable the two-word LI pseudo-instruction.
module inst_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_alu_func,
  input  logic [2:0]  in_br_func,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD
`ifdef INST_ENCODER_LI_EN
    , S_HOLD_LI
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic        accept;
  logic [31:0] pk_inst;
  logic        pk_err;
`ifdef INST_ENCODER_LI_EN
  logic [31:0] queue_q, queue_d;
  logic [31:0] pk_inst2;
  logic        pk_two;
`endif

  inst_pack u_pack (
    .op_i       (in_op),
    .alu_func_i (in_alu_func),
    .br_func_i  (in_br_func),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .imm_i      (in_imm),
`ifdef INST_ENCODER_LI_EN
    .two_word_o (pk_two),
    .inst2_o    (pk_inst2),
`endif
    .inst_o     (pk_inst),
    .err_o      (pk_err)
  );

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != S_IDLE);
  assign out_inst  = inst_q;
  assign out_err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      inst_q  <= '0;
      err_q   <= 1'b0;
`ifdef INST_ENCODER_LI_EN
      queue_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
`ifdef INST_ENCODER_LI_EN
      queue_q <= queue_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    err_d   = err_q;
`ifdef INST_ENCODER_LI_EN
    queue_d = queue_q;
`endif
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          inst_d  = pk_inst;
          err_d   = pk_err;
          state_d = S_HOLD;
`ifdef INST_ENCODER_LI_EN
          queue_d = pk_inst2;
          if (pk_two) state_d = S_HOLD_LI;
`endif
        end else if (state_q == S_HOLD && out_ready) begin
          state_d = S_IDLE;
        end
      end
`ifdef INST_ENCODER_LI_EN
      // LUI word drains first; the queued ADDI becomes the pending word.
      S_HOLD_LI: begin
        if (out_ready) begin
          inst_d  = queue_q;
          err_d   = 1'b0;
          state_d = S_HOLD;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: queue-based reference model checked every cycle.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0]  in_op, in_alu_func;
  logic [2:0]  in_br_func;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_inst;
  logic        done = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed { logic [31:0] w; logic e; } exp_t;
  exp_t sb[$];

  localparam int AF3 [10] = '{0, 0, 7, 6, 4, 2, 3, 1, 5, 5};
  localparam int BF3 [6]  = '{0, 1, 4, 5, 6, 7};

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_alu_func(in_alu_func), .in_br_func(in_br_func),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err)
  );

  // Instruction formats assembled with plain integer arithmetic.
  function automatic logic [31:0] fr(int f7, int rs2, int rs1, int f3, int rd, int opc);
    return (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + opc;
  endfunction
  function automatic logic [31:0] fi(int imm, int rs1, int f3, int rd, int opc);
    return ((imm & 4095) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + opc;
  endfunction
  function automatic logic [31:0] fs(int imm, int rs2, int rs1, int f3, int opc);
    return (((imm >> 5) & 127) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
           + ((imm & 31) << 7) + opc;
  endfunction
  function automatic logic [31:0] fb(int imm, int rs2, int rs1, int f3, int opc);
    return (((imm >> 12) & 1) << 31) + (((imm >> 5) & 63) << 25) + (rs2 << 20) + (rs1 << 15)
           + (f3 << 12) + (((imm >> 1) & 15) << 8) + (((imm >> 11) & 1) << 7) + opc;
  endfunction
  function automatic logic [31:0] fu(int imm, int rd, int opc);
    return (imm & 32'hFFFFF000) + (rd << 7) + opc;
  endfunction
  function automatic logic [31:0] fj(int imm, int rd, int opc);
    return (((imm >> 20) & 1) << 31) + (((imm >> 1) & 1023) << 21) + (((imm >> 11) & 1) << 20)
           + (((imm >> 12) & 255) << 12) + (rd << 7) + opc;
  endfunction

  function automatic void model(input logic [3:0] op, input logic [3:0] alu, input logic [2:0] br,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, output int n, output logic [31:0] w0,
                                output logic [31:0] w1, output logic err);
    int si, lo;
    si = imm;
    n = 1; w0 = 32'h13; w1 = 32'h13; err = 1'b0;
    case (op)
      0: if (alu > 9) err = 1'b1;
         else w0 = fr((alu == 1 || alu == 9) ? 32 : 0, rs2, rs1, AF3[alu], rd, 'h33);
      1: if (alu > 9 || alu == 1) err = 1'b1;
         else if (alu >= 7) begin
           if (imm > 32'd31) err = 1'b1;
           else w0 = fi(((alu == 9) ? 'h400 : 0) + si, rs1, AF3[alu], rd, 'h13);
         end else if (si < -2048 || si > 2047) err = 1'b1;
         else w0 = fi(si, rs1, AF3[alu], rd, 'h13);
      2, 3: if ((si & 4095) != 0) err = 1'b1;
            else w0 = fu(si, rd, (op == 2) ? 'h37 : 'h17);
      4: if (si < -(1 << 20) || si >= (1 << 20) || (si & 1) != 0) err = 1'b1;
         else w0 = fj(si, rd, 'h6F);
      5: if (si < -2048 || si > 2047) err = 1'b1; else w0 = fi(si, rs1, 0, rd, 'h67);
      6: if (br > 5 || si < -4096 || si > 4095 || (si & 1) != 0) err = 1'b1;
         else w0 = fb(si, rs2, rs1, BF3[br], 'h63);
      7: if (si < -2048 || si > 2047) err = 1'b1; else w0 = fi(si, rs1, 2, rd, 'h03);
      8: if (si < -2048 || si > 2047) err = 1'b1; else w0 = fs(si, rs2, rs1, 2, 'h23);
`ifdef INST_ENCODER_LI_EN
      9: if (si >= -2048 && si <= 2047) w0 = fi(si, 0, 0, rd, 'h13);
         else begin
           lo = ((si & 4095) ^ 2048) - 2048;
           w0 = fu(si - lo, rd, 'h37);
           if (lo != 0) begin n = 2; w1 = fi(lo, rd, 0, rd, 'h13); end
         end
`endif
      default: err = 1'b1;
    endcase
    if (err) begin w0 = 32'h13; n = 1; end
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", nm, a, e, $time);
    end
  endtask
  task automatic chk1(input string nm, input logic a, input logic e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Model pins against hand-assembled words, then per-cycle DUT comparison.
  initial begin
    int n, cyc;
    logic [31:0] w0, w1;
    logic e, exp_v, exp_r;
    model(0, 0, 0, 3, 1, 2, 0, n, w0, w1, e);          chk("pin_add", w0, 32'h002081B3);
    model(0, 1, 0, 1, 2, 3, 0, n, w0, w1, e);          chk("pin_sub", w0, 32'h403100B3);
    model(1, 0, 0, 1, 0, 0, 1, n, w0, w1, e);          chk("pin_addi", w0, 32'h00100093);
    model(4, 0, 0, 1, 0, 0, 8, n, w0, w1, e);          chk("pin_jal", w0, 32'h008000EF);
    model(8, 0, 0, 0, 1, 2, 8, n, w0, w1, e);          chk("pin_sw", w0, 32'h0020A423);
    model(6, 0, 1, 0, 1, 2, 8, n, w0, w1, e);          chk("pin_bne", w0, 32'h00209463);
    model(6, 0, 0, 0, 1, 2, 3, n, w0, w1, e);          chk("pin_beq_odd", {w0[30:0], e}, 32'h00000027);
    model(2, 0, 0, 1, 0, 0, 32'h1001, n, w0, w1, e);   chk("pin_lui_bad", {w0[30:0], e}, 32'h00000027);
`ifdef INST_ENCODER_LI_EN
    model(9, 0, 0, 5, 0, 0, 32'h12345678, n, w0, w1, e);
    chk("pin_li_w0", w0, 32'h123452B7); chk("pin_li_w1", w1, 32'h67828293); chk("pin_li_n", n, 2);
`else
    model(9, 0, 0, 5, 0, 0, 5, n, w0, w1, e);          chk("pin_li_off", {w0[30:0], e}, 32'h00000027);
`endif
    cyc = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin chk1("watchdog", 1'b1, 1'b0); break; end
      if (rst) begin
        sb.delete();
        chk1("rst_valid", out_valid, 1'b0);
        chk("rst_inst", out_inst, 32'h0);
        chk1("rst_err", out_err, 1'b0);
        chk1("rst_ready", in_ready, 1'b1);
      end else begin
        exp_v = (sb.size() > 0);
        exp_r = (sb.size() == 0) || (sb.size() == 1 && out_ready);
        chk1("out_valid", out_valid, exp_v);
        chk1("in_ready", in_ready, exp_r);
        if (exp_v && out_valid) begin
          chk("out_inst", out_inst, sb[0].w);
          chk1("out_err", out_err, sb[0].e);
        end
        if (exp_v && out_ready) void'(sb.pop_front());
        if (in_valid && exp_r) begin
          model(in_op, in_alu_func, in_br_func, in_rd, in_rs1, in_rs2, in_imm, n, w0, w1, e);
          sb.push_back('{w: w0, e: e});
          if (n == 2) sb.push_back('{w: w1, e: 1'b0});
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] alu, input logic [2:0] br,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    in_op = op; in_alu_func = alu; in_br_func = br;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !in_ready; k++) step(1);
    step(1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_alu_func = '0; in_br_func = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    step(3);
    rst = 1'b0;
    step(1);
    // Back-to-back stream with the sink always ready.
    send(0, 0, 0, 3, 1, 2, 0);          send(0, 1, 0, 1, 2, 3, 0);
    send(0, 2, 0, 4, 5, 6, 0);          send(0, 9, 0, 7, 8, 9, 0);
    send(0, 12, 0, 1, 1, 1, 0);         send(1, 0, 0, 2, 3, 0, 32'hFFFFFFFB);
    send(1, 7, 0, 2, 3, 0, 31);         send(1, 7, 0, 2, 3, 0, 32);
    send(1, 9, 0, 6, 7, 0, 4);          send(1, 1, 0, 2, 3, 0, 1);
    send(1, 2, 0, 2, 3, 0, 2047);       send(1, 3, 0, 2, 3, 0, 2048);
    send(2, 0, 0, 7, 0, 0, 32'h12345000); send(2, 0, 0, 1, 0, 0, 32'h00001001);
    send(3, 0, 0, 8, 0, 0, 32'hFFFFF000); send(4, 0, 0, 1, 0, 0, 32'h000FFFFE);
    send(4, 0, 0, 1, 0, 0, 32'hFFF00000); send(4, 0, 0, 1, 0, 0, 32'h00100000);
    send(4, 0, 0, 1, 0, 0, 7);          send(5, 0, 0, 1, 2, 0, 2047);
    send(5, 0, 0, 1, 2, 0, 2048);       send(6, 0, 0, 0, 1, 2, 3);
    send(6, 0, 1, 0, 3, 4, 32'hFFFFF000); send(6, 0, 5, 0, 5, 6, 4094);
    send(6, 0, 6, 0, 1, 2, 8);          send(6, 0, 2, 0, 1, 2, 4096);
    send(7, 0, 0, 9, 10, 0, 32'hFFFFF800); send(8, 0, 0, 0, 11, 12, 32'h7FF);
    send(8, 0, 0, 0, 11, 12, 32'hFFFFF7FF); send(10, 0, 0, 1, 1, 1, 0);
    send(15, 0, 0, 1, 1, 1, 0);         send(9, 0, 0, 5, 0, 0, 5);
    send(9, 0, 0, 5, 0, 0, 32'h12345678); send(9, 0, 0, 6, 0, 0, 32'hFFFFF800);
    send(9, 0, 0, 7, 0, 0, 32'h00001000); send(9, 0, 0, 8, 0, 0, 32'h00000800);
    in_valid = 1'b0;
    step(3);
    // Sink stalls for three cycles; the waiting request is taken as out_ready rises.
    out_ready = 1'b0;
    send(1, 0, 0, 1, 0, 0, 1);
    in_op = 0; in_alu_func = 0; in_rd = 3; in_rs1 = 1; in_rs2 = 2; in_imm = 0;
    step(2);
    out_ready = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(3);
    // LI under backpressure followed by a request that must wait for the queue.
    out_ready = 1'b0;
    send(9, 0, 0, 5, 0, 0, 32'h12345678);
    in_valid = 1'b0;
    step(2);
    out_ready = 1'b1;
    send(4, 0, 0, 1, 0, 0, 8);
    in_valid = 1'b0;
    step(3);
    // Reset one cycle after an LI is accepted; nothing may emerge afterwards.
    send(9, 0, 0, 5, 0, 0, 32'h12345678);
    in_valid = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(4);
    send(0, 0, 0, 3, 1, 2, 0);
    in_valid = 1'b0;
    step(3);
    done = 1'b1;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 in_valid / in_ready  input / output  1 / 1  request handshake; a request is accepted on a cycle where both are 1.
REQ-004 in_op  input  4  op class: 0 R-ALU, 1 I-ALU, 2 LUI, 3 AUIPC, 4 JAL, 5 JALR, 6 BRANCH, 7 LOAD(lw), 8 STORE(sw), 9 LI pseudo; 10-15 invalid.
REQ-005 in_alu_func  input  4  add 0, sub 1, and 2, or 3, xor 4, slt 5, sltu 6, sll 7, srl 8, sra 9; other values invalid.
REQ-006 in_br_func  input  3  beq 0, bne 1, blt 2, bge 3, bltu 4, bgeu 5; 6-7 invalid.
REQ-007 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-008 in_imm  input  32  full signed immediate value, not pre-shifted.
REQ-009 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-010 out_inst  output  32  encoded RV32I instruction word.
REQ-011 out_err  output  1  qualifies out_inst; 1 = request was unencodable.

Function
REQ-012 Output is registered: a request accepted in cycle N produces out_valid=1 from cycle N+1.
REQ-013 out_inst, out_valid and out_err hold stable while out_valid=1 and out_ready=0.
REQ-014 FSM states: IDLE (output empty), HOLD (one word pending), HOLD_LI (LUI word pending, ADDI queued).
REQ-015 in_ready = (IDLE) or (HOLD and out_ready); in_ready=0 in HOLD_LI, giving full throughput for single-word ops.
REQ-016 Transitions: IDLE->HOLD on accept; HOLD->HOLD on simultaneous drain and accept; HOLD->IDLE on drain without accept; IDLE/HOLD->HOLD_LI when an accepted LI needs two words; HOLD_LI->HOLD on drain, loading the queued ADDI.
REQ-017 Immediate legality:
- I-ALU, LOAD, JALR, STORE: signed 12-bit.
- Shifts: 0..31.
- BRANCH: signed 13-bit, even.
- JAL: signed 21-bit, even.
- LUI/AUIPC: in_imm[11:0]=0.
REQ-018 An invalid op, invalid func code, invalid func for the op class (e.g. sub with I-ALU), or an illegal immediate emits 0x00000013 (NOP) with out_err=1.
REQ-019 LI with in_imm in [-2048, 2047]: single word ADDI rd,x0,imm.
REQ-020 Other LI values:
- First word: LUI rd, (in_imm+0x800)>>12, computed mod 2^32.
- Second word: ADDI rd,rd,in_imm[11:0], omitted when in_imm[11:0]=0.
REQ-021 Field packing uses the standard RV32I opcodes, funct3 and funct7 values.

Reset
REQ-022 rst forces IDLE with out_valid=0, out_inst=0, out_err=0 and in_ready=1 on the next evaluation.
REQ-023 rst asserted in HOLD_LI discards the queued ADDI; the ADDI is never emitted.

Configuration
REQ-024 Macro INST_ENCODER_LI_EN: when defined, LI is supported per REQ-019/020; when undefined, HOLD_LI and its queue register are removed and in_op=9 is treated as invalid (NOP, out_err=1).

Structure
REQ-025 Shared package riscv_pkg holds:
- opcode constants;
- ALU and branch func encodings;
- op-class enum;
- NOP constant 32'h00000013.
REQ-026 Combinational sub-module inst_pack holds field packing and legality checks; inst_encoder holds the FSM and registers.

Verification
REQ-027 R-ALU add rd=3,rs1=1,rs2=2 -> 0x002081B3, out_err=0; sub rd=1,rs1=2,rs2=3 -> 0x403100B3.
REQ-028 LI rd=5, imm=0x12345678, out_ready=1 -> 0x123452B7 then 0x67828293 on consecutive cycles; in_ready=0 for one cycle.
REQ-029 BRANCH beq with imm=3 -> 0x00000013, out_err=1; LUI with imm=0x00001001 -> NOP, out_err=1.
REQ-030 out_ready=0 for 3 cycles after ADDI x1,x0,1 -> out_inst held at 0x00100093; in_ready=0; a next request is accepted in the same cycle out_ready rises.
REQ-031 rst pulsed in the cycle after LI rd=5, imm=0x12345678 is accepted -> out_valid=0 and 0x67828293 never appears.
REQ-032 Build without INST_ENCODER_LI_EN, then LI imm=5 -> NOP, out_err=1.
